// File: rtl/axi_sram_slv.sv
// AXI slave fronting a word-addressed on-chip SRAM: one transaction at a time,
// single shared memory port, alternating read/write priority on collisions.
module axi_sram_slv #(
    parameter int          AW_MEM = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  s_awid,
    input  logic [31:0] s_awaddr,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic [9:0]  s_wid,
    input  logic        s_wlast,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [9:0]  s_bid,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [9:0]  s_arid,
    input  logic [31:0] s_araddr,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic [9:0]  s_rid,
    output logic        s_rlast,
    output logic        s_rvalid,
    input  logic        s_rready
);
    localparam logic [31:0] SIZE_B = 32'd4 << AW_MEM;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREAD, RDATA} state_t;

    state_t      state;
    logic [9:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  cnt;
    logic [1:0]  burst;
    logic        err;
    logic        prio_rd;
    logic        grant_wr;
    logic        grant_rd;
    logic        beat_err;
    logic        last_beat;
    logic        wlast_bad;
    logic        mem_we;
    logic        unused_wid;

    logic [31:0] mem [0:(1<<AW_MEM)-1];

    function automatic logic out_of_range(input logic [31:0] a);
        return (a - BASE) >= SIZE_B;
    endfunction

    function automatic logic [AW_MEM-1:0] word_idx(input logic [31:0] a);
        return AW_MEM'((a - BASE) >> 2);
    endfunction

    // Priority bit only matters when both address channels are valid together.
    always_comb begin
        grant_wr = s_awvalid && (!s_arvalid || !prio_rd);
        grant_rd = s_arvalid && (!s_awvalid || prio_rd);
    end

    assign s_awready  = !rst && (state == IDLE) && grant_wr;
    assign s_arready  = !rst && (state == IDLE) && grant_rd;
    assign s_wready   = (state == WDATA);
    assign beat_err   = err | out_of_range(addr);
    assign last_beat  = (cnt == len);
    assign wlast_bad  = (s_wlast != last_beat);
    assign mem_we     = !rst && (state == WDATA) && s_wvalid && !beat_err;
    assign unused_wid = ^s_wid;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem[word_idx(addr)][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio_rd  <= 1'b1;
            id       <= '0;
            addr     <= '0;
            len      <= '0;
            cnt      <= '0;
            burst    <= '0;
            err      <= 1'b0;
            s_bvalid <= 1'b0;
            s_bid    <= '0;
            s_bresp  <= '0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= '0;
            s_rid    <= '0;
            s_rlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        id      <= s_awid;
                        addr    <= s_awaddr;
                        len     <= s_awlen;
                        burst   <= s_awburst;
                        err     <= (s_awsize != 3'd2) | out_of_range(s_awaddr);
                        cnt     <= '0;
                        state   <= WDATA;
                        if (s_arvalid) prio_rd <= 1'b1;
                    end else if (grant_rd) begin
                        id      <= s_arid;
                        addr    <= s_araddr;
                        len     <= s_arlen;
                        burst   <= s_arburst;
                        err     <= (s_arsize != 3'd2) | out_of_range(s_araddr);
                        cnt     <= '0;
                        state   <= RREAD;
                        if (s_awvalid) prio_rd <= 1'b0;
                    end
                end
                WDATA: begin
                    // Burst length follows awlen; a wlast mismatch only flags the error.
                    if (s_wvalid) begin
                        err <= beat_err | wlast_bad;
                        cnt <= cnt + 8'd1;
                        if (burst != 2'b00) addr <= addr + 32'd4;
                        if (last_beat) begin
                            state    <= WRESP;
                            s_bvalid <= 1'b1;
                            s_bid    <= id;
                            s_bresp  <= (beat_err | wlast_bad) ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RREAD: begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= beat_err ? 32'd0 : mem[word_idx(addr)];
                    s_rresp  <= beat_err ? 2'b10 : 2'b00;
                    s_rid    <= id;
                    s_rlast  <= last_beat;
                    err      <= beat_err;
                    state    <= RDATA;
                end
                RDATA: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        if (s_rlast) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + 8'd1;
                            if (burst != 2'b00) addr <= addr + 32'd4;
                            state <= RREAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
